// File: rtl/axi_lite_mem_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_mem_initiator
//  Brief    : AXI4-lite initiator bridging a picorv32-style native memory port
//             (mem_valid/mem_ready) onto AXI4-lite read/write channels. One
//             outstanding transaction at a time, with a sticky watchdog flag
//             for responders that stall.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_mem_initiator #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_W      = 16
) (
    input  logic        clk,
    input  logic        resetn,
    // native memory port
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    // AXI4-lite write address
    output logic        mem_axi_awvalid,
    input  logic        mem_axi_awready,
    output logic [31:0] mem_axi_awaddr,
    output logic [2:0]  mem_axi_awprot,
    // AXI4-lite write data
    output logic        mem_axi_wvalid,
    input  logic        mem_axi_wready,
    output logic [31:0] mem_axi_wdata,
    output logic [3:0]  mem_axi_wstrb,
    // AXI4-lite write response
    input  logic        mem_axi_bvalid,
    output logic        mem_axi_bready,
    // AXI4-lite read address
    output logic        mem_axi_arvalid,
    input  logic        mem_axi_arready,
    output logic [31:0] mem_axi_araddr,
    output logic [2:0]  mem_axi_arprot,
    // AXI4-lite read data
    input  logic        mem_axi_rvalid,
    output logic        mem_axi_rready,
    input  logic [31:0] mem_axi_rdata,
    // watchdog
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_WB   = 3'd2,
        S_RA   = 3'd3,
        S_RD   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      state, state_nx;

    // latched request payload; drives the AXI address/data outputs directly
    logic [31:0] req_addr,  req_addr_nx;
    logic [31:0] req_wdata, req_wdata_nx;
    logic [3:0]  req_wstrb, req_wstrb_nx;
    logic        req_instr, req_instr_nx;

    // write-channel completion tracking (AW and W finish independently)
    logic        aw_done, aw_done_nx;
    logic        w_done,  w_done_nx;

    logic        awvalid_nx, wvalid_nx, bready_nx, arvalid_nx, rready_nx;
    logic        mem_ready_nx;
    logic [31:0] mem_rdata_nx;

    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign aw_hs = mem_axi_awvalid & mem_axi_awready;
    assign w_hs  = mem_axi_wvalid  & mem_axi_wready;
    assign b_hs  = mem_axi_bvalid  & mem_axi_bready;
    assign ar_hs = mem_axi_arvalid & mem_axi_arready;
    assign r_hs  = mem_axi_rvalid  & mem_axi_rready;

    assign mem_axi_awaddr = req_addr;
    assign mem_axi_araddr = req_addr;
    assign mem_axi_wdata  = req_wdata;
    assign mem_axi_wstrb  = req_wstrb;
    assign mem_axi_awprot = 3'b000;
    assign mem_axi_arprot = {req_instr, 2'b00};

    // State register and registered outputs; reset aborts any transaction
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= S_IDLE;
            req_addr        <= 32'd0;
            req_wdata       <= 32'd0;
            req_wstrb       <= 4'd0;
            req_instr       <= 1'b0;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            mem_axi_awvalid <= 1'b0;
            mem_axi_wvalid  <= 1'b0;
            mem_axi_bready  <= 1'b0;
            mem_axi_arvalid <= 1'b0;
            mem_axi_rready  <= 1'b0;
            mem_ready       <= 1'b0;
            mem_rdata       <= 32'd0;
        end else begin
            state           <= state_nx;
            req_addr        <= req_addr_nx;
            req_wdata       <= req_wdata_nx;
            req_wstrb       <= req_wstrb_nx;
            req_instr       <= req_instr_nx;
            aw_done         <= aw_done_nx;
            w_done          <= w_done_nx;
            mem_axi_awvalid <= awvalid_nx;
            mem_axi_wvalid  <= wvalid_nx;
            mem_axi_bready  <= bready_nx;
            mem_axi_arvalid <= arvalid_nx;
            mem_axi_rready  <= rready_nx;
            mem_ready       <= mem_ready_nx;
            mem_rdata       <= mem_rdata_nx;
        end
    end

    // Next-state and next-output logic; every valid/ready holds unless changed
    always_comb begin
        state_nx     = state;
        req_addr_nx  = req_addr;
        req_wdata_nx = req_wdata;
        req_wstrb_nx = req_wstrb;
        req_instr_nx = req_instr;
        aw_done_nx   = aw_done;
        w_done_nx    = w_done;
        awvalid_nx   = mem_axi_awvalid;
        wvalid_nx    = mem_axi_wvalid;
        bready_nx    = mem_axi_bready;
        arvalid_nx   = mem_axi_arvalid;
        rready_nx    = mem_axi_rready;
        mem_ready_nx = 1'b0;
        mem_rdata_nx = mem_rdata;

        case (state)
            S_IDLE: begin
                aw_done_nx = 1'b0;
                w_done_nx  = 1'b0;
                if (mem_valid) begin
                    req_addr_nx  = mem_addr;
                    req_wdata_nx = mem_wdata;
                    req_wstrb_nx = mem_wstrb;
                    req_instr_nx = mem_instr;
                    if (mem_wstrb != 4'b0000) begin
                        state_nx   = S_WR;
                        awvalid_nx = 1'b1;
                        wvalid_nx  = 1'b1;
                    end else begin
                        state_nx   = S_RA;
                        arvalid_nx = 1'b1;
                    end
                end
            end
            S_WR: begin
                if (aw_hs) begin
                    awvalid_nx = 1'b0;
                    aw_done_nx = 1'b1;
                end
                if (w_hs) begin
                    wvalid_nx = 1'b0;
                    w_done_nx = 1'b1;
                end
                // handshakes in this very cycle count towards completion
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_nx  = S_WB;
                    bready_nx = 1'b1;
                end
            end
            S_WB: begin
                if (b_hs) begin
                    bready_nx    = 1'b0;
                    state_nx     = S_DONE;
                    mem_ready_nx = 1'b1;
                end
            end
            S_RA: begin
                if (ar_hs) begin
                    arvalid_nx = 1'b0;
                    rready_nx  = 1'b1;
                    state_nx   = S_RD;
                end
            end
            S_RD: begin
                if (r_hs) begin
                    mem_rdata_nx = mem_axi_rdata;
                    rready_nx    = 1'b0;
                    state_nx     = S_DONE;
                    mem_ready_nx = 1'b1;
                end
            end
            S_DONE: begin
                // mem_valid is deliberately not looked at here so a request
                // still held during the ready pulse is not issued twice
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_watchdog
            localparam logic [TIMEOUT_W-1:0] C_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);
            logic [TIMEOUT_W-1:0] wd_cnt;

            // Count busy cycles, saturate at the limit and latch the error flag
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    wd_cnt      <= '0;
                    timeout_err <= 1'b0;
                end else begin
                    if (state == S_IDLE) begin
                        wd_cnt <= '0;
                    end else if (wd_cnt != C_LIMIT) begin
                        wd_cnt <= wd_cnt + TIMEOUT_W'(1);
                    end
                    if (wd_cnt == C_LIMIT) begin
                        timeout_err <= 1'b1;
                    end
                end
            end
        end else begin : g_no_watchdog
            assign timeout_err = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_mem_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lite_mem_initiator
//  Brief    : Self-checking bench for axi_lite_mem_initiator with a small
//             AXI4-lite memory responder (configurable ready/response delays).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_mem_initiator;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid = 1'b0, mem_instr = 1'b0;
    logic [31:0] mem_addr = 32'd0, mem_wdata = 32'd0;
    logic [3:0]  mem_wstrb = 4'd0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_axi_awvalid, mem_axi_awready = 1'b0;
    logic [31:0] mem_axi_awaddr;
    logic [2:0]  mem_axi_awprot;
    logic        mem_axi_wvalid, mem_axi_wready = 1'b0;
    logic [31:0] mem_axi_wdata;
    logic [3:0]  mem_axi_wstrb;
    logic        mem_axi_bvalid = 1'b0, mem_axi_bready;
    logic        mem_axi_arvalid, mem_axi_arready = 1'b0;
    logic [31:0] mem_axi_araddr;
    logic [2:0]  mem_axi_arprot;
    logic        mem_axi_rvalid = 1'b0, mem_axi_rready;
    logic [31:0] mem_axi_rdata = 32'd0;
    logic        timeout_err;

    axi_lite_mem_initiator #(.TIMEOUT_CYCLES(8), .TIMEOUT_W(4)) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
        .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
        .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
        .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
        .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
        .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
        .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
        .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
        .mem_axi_rdata(mem_axi_rdata),
        .timeout_err(timeout_err)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Responder: memory model driven on the falling edge
    // ------------------------------------------------------------------
    logic [31:0] mem [0:255];
    int  ar_delay = 0, aw_delay = 0, w_delay = 0;
    bit  r_en = 1'b1, b_en = 1'b1;
    int  ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
    int  ar_total = 0, aw_total = 0, w_total = 0;
    bit  ar_hs_p = 0, r_hs_p = 0, aw_hs_p = 0, w_hs_p = 0, b_hs_p = 0;
    bit  r_pend = 0, aw_got = 0, w_got = 0, b_owed = 0;
    bit  pv_ar = 0, pv_aw = 0, pv_w = 0;
    logic [34:0] pp_ar = '0;
    logic [31:0] pp_aw = '0;
    logic [35:0] pp_w  = '0;
    logic [31:0] rd_a = '0, wr_a = '0, wr_d = '0;
    logic [3:0]  wr_s = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                mem_axi_arready = 0; mem_axi_awready = 0; mem_axi_wready = 0;
                mem_axi_rvalid = 0; mem_axi_bvalid = 0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
                ar_hs_p = 0; r_hs_p = 0; aw_hs_p = 0; w_hs_p = 0; b_hs_p = 0;
                r_pend = 0; aw_got = 0; w_got = 0; b_owed = 0;
                pv_ar = 0; pv_aw = 0; pv_w = 0;
            end else begin
                // a raised valid must hold with stable payload until accepted
                if (pv_ar && !ar_hs_p)
                    check("ar_hold", {28'd0, mem_axi_arvalid, mem_axi_arprot, mem_axi_araddr}, {28'd0, 1'b1, pp_ar});
                if (pv_aw && !aw_hs_p)
                    check("aw_hold", {31'd0, mem_axi_awvalid, mem_axi_awaddr}, {31'd0, 1'b1, pp_aw});
                if (pv_w && !w_hs_p)
                    check("w_hold", {27'd0, mem_axi_wvalid, mem_axi_wstrb, mem_axi_wdata}, {27'd0, 1'b1, pp_w});
                // effects of handshakes at the rising edge just passed
                if (ar_hs_p) begin r_pend = 1; rd_a = pp_ar[31:0]; ar_total++; ar_cnt = 0; end
                if (r_hs_p)  mem_axi_rvalid = 0;
                if (aw_hs_p) begin aw_got = 1; wr_a = pp_aw; aw_total++; aw_cnt = 0; end
                if (w_hs_p)  begin w_got = 1; wr_d = pp_w[31:0]; wr_s = pp_w[35:32]; w_total++; w_cnt = 0; end
                if (b_hs_p)  mem_axi_bvalid = 0;
                if (aw_got && w_got) begin
                    for (int b = 0; b < 4; b++)
                        if (wr_s[b]) mem[wr_a[9:2]][8*b +: 8] = wr_d[8*b +: 8];
                    aw_got = 0; w_got = 0; b_owed = 1;
                end
                if (b_owed && b_en && !mem_axi_bvalid) begin mem_axi_bvalid = 1; b_owed = 0; end
                if (r_pend && r_en && !mem_axi_rvalid) begin
                    mem_axi_rvalid = 1; mem_axi_rdata = mem[rd_a[9:2]]; r_pend = 0;
                end
                // ready generation with per-channel wait counts
                mem_axi_arready = (ar_cnt >= ar_delay);
                if (mem_axi_arvalid && !mem_axi_arready) ar_cnt++;
                mem_axi_awready = (aw_cnt >= aw_delay);
                if (mem_axi_awvalid && !mem_axi_awready) aw_cnt++;
                mem_axi_wready = (w_cnt >= w_delay);
                if (mem_axi_wvalid && !mem_axi_wready) w_cnt++;
                // handshakes that will happen at the next rising edge
                ar_hs_p = mem_axi_arvalid && mem_axi_arready;
                r_hs_p  = mem_axi_rvalid && mem_axi_rready;
                aw_hs_p = mem_axi_awvalid && mem_axi_awready;
                w_hs_p  = mem_axi_wvalid && mem_axi_wready;
                b_hs_p  = mem_axi_bvalid && mem_axi_bready;
                pv_ar = mem_axi_arvalid; pp_ar = {mem_axi_arprot, mem_axi_araddr};
                pv_aw = mem_axi_awvalid; pp_aw = mem_axi_awaddr;
                pv_w  = mem_axi_wvalid;  pp_w  = {mem_axi_wstrb, mem_axi_wdata};
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic ins);
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = ins;
    endtask

    task automatic start_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic ins);
        @(negedge clk);
        set_req(a, d, s, ins);
        cyc = 0;
    endtask

    task automatic wait_ready(input int bound, input bit keep, output int lat);
        lat = -1;
        for (int k = 0; k < bound; k++) begin
            step();
            if (mem_ready) begin
                lat = cyc;
                if (!keep) mem_valid = 1'b0;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++; n_fail++;
            $display("FAIL ready_timeout: no mem_ready within %0d cycles, expected one pulse", bound);
            mem_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; mem_valid = 1'b0;
        step(); step();
        resetn = 1'b1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_ctrl"}, {57'd0, mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready,
              mem_axi_arvalid, mem_axi_rready, mem_ready, timeout_err}, 64'd0);
        check({tag, "_rdata"}, {32'd0, mem_rdata}, 64'd0);
        check({tag, "_addr"}, {mem_axi_awaddr, mem_axi_araddr}, 64'd0);
        check({tag, "_wdata"}, {22'd0, mem_axi_wdata, mem_axi_wstrb, mem_axi_arprot, mem_axi_awprot}, 64'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
        logic [31:0] exp_rdata;  // mem_rdata after completion
        logic [31:0] exp_mem;    // memory word after a write
    } vec_t;

    vec_t vt [7];
    int   lat, prev_c, ar0, aw0, w0, pulses;
    logic [31:0] a4 [4], d4 [4], e4 [4];
    logic [3:0]  s4 [4];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[8'h40] = 32'h1234_5678;   // 0x100
        mem[8'h42] = 32'h0102_0304;   // 0x108
        mem[8'h80] = 32'h1122_3344;   // 0x200
        mem[8'h81] = 32'h1122_3344;   // 0x204

        vt[0] = '{32'h100, 32'h0,         4'b0000, 1'b0, 32'h1234_5678, 32'h0};
        vt[1] = '{32'h204, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h1234_5678, 32'h11BB_33DD};
        vt[2] = '{32'h204, 32'h0,         4'b0000, 1'b1, 32'h11BB_33DD, 32'h0};
        vt[3] = '{32'h104, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h11BB_33DD, 32'hCAFE_F00D};
        vt[4] = '{32'h108, 32'h5A00_0000, 4'b1000, 1'b0, 32'h11BB_33DD, 32'h5A02_0304};
        vt[5] = '{32'h108, 32'h0,         4'b0000, 1'b0, 32'h5A02_0304, 32'h0};
        vt[6] = '{32'h104, 32'h0,         4'b0000, 1'b1, 32'hCAFE_F00D, 32'h0};

        // reset state
        do_reset();
        check_cleared("reset");

        // zero-wait table: first-cycle channel outputs, latency, data
        for (int i = 0; i < 7; i++) begin
            start_req(vt[i].addr, vt[i].wdata, vt[i].wstrb, vt[i].instr);
            step();
            if (vt[i].wstrb == 4'b0000) begin
                check($sformatf("v%0d_ar", i), {26'd0, mem_axi_arvalid, mem_axi_awvalid, mem_axi_wvalid,
                      mem_axi_arprot, mem_axi_araddr}, {26'd0, 3'b100, vt[i].instr, 2'b00, vt[i].addr});
            end else begin
                check($sformatf("v%0d_aw", i), {20'd0, mem_axi_arvalid, mem_axi_awvalid, mem_axi_wvalid,
                      mem_axi_awprot, mem_axi_wstrb, mem_axi_awaddr}, {20'd0, 3'b011, 3'b000, vt[i].wstrb, vt[i].addr});
                check($sformatf("v%0d_wdata", i), {32'd0, mem_axi_wdata}, {32'd0, vt[i].wdata});
            end
            wait_ready(20, 1'b0, lat);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'd3);
            check($sformatf("v%0d_rdata", i), {32'd0, mem_rdata}, {32'd0, vt[i].exp_rdata});
            if (vt[i].wstrb != 4'b0000)
                check($sformatf("v%0d_mem", i), {32'd0, mem[vt[i].addr[9:2]]}, {32'd0, vt[i].exp_mem});
        end
        check("short_txn_no_timeout", {63'd0, timeout_err}, 64'd0);

        // write with W accepted three cycles after AW
        w_delay = 3;
        aw0 = aw_total; w0 = w_total;
        start_req(32'h200, 32'hAABB_CCDD, 4'b0101, 1'b0);
        step();
        check("t3_c1_valids", {62'd0, mem_axi_awvalid, mem_axi_wvalid}, 64'd3);
        step();
        check("t3_c2_valids", {62'd0, mem_axi_awvalid, mem_axi_wvalid}, 64'd1);
        wait_ready(20, 1'b0, lat);
        check("t3_latency", 64'(lat), 64'd6);
        check("t3_mem", {32'd0, mem[8'h80]}, 64'h11BB_33DD);
        w_delay = 0;
        step(); step(); step();
        check("t3_hs_count", {32'(aw_total - aw0), 32'(w_total - w0)}, {32'd1, 32'd1});

        // back-to-back mixed requests with mem_valid held high throughout
        a4[0] = 32'h300; d4[0] = 32'h0BAD_BEEF; s4[0] = 4'b1111; e4[0] = 32'h0;
        a4[1] = 32'h300; d4[1] = 32'h0;         s4[1] = 4'b0000; e4[1] = 32'h0BAD_BEEF;
        a4[2] = 32'h304; d4[2] = 32'h1234_ABCD; s4[2] = 4'b0011; e4[2] = 32'h0;
        a4[3] = 32'h304; d4[3] = 32'h0;         s4[3] = 4'b0000; e4[3] = 32'h0000_ABCD;
        ar0 = ar_total; aw0 = aw_total; w0 = w_total; prev_c = 0;
        start_req(a4[0], d4[0], s4[0], 1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_ready(20, 1'b1, lat);
            check($sformatf("t4_gap%0d", i), 64'(lat - prev_c), (i == 0) ? 64'd3 : 64'd4);
            if (s4[i] == 4'b0000)
                check($sformatf("t4_rdata%0d", i), {32'd0, mem_rdata}, {32'd0, e4[i]});
            prev_c = lat;
            if (i < 3) set_req(a4[i+1], d4[i+1], s4[i+1], 1'b0);
        end
        mem_valid = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin step(); if (mem_ready) pulses++; end
        check("t4_no_extra_ready", 64'(pulses), 64'd0);
        check("t4_hs_count", {16'(ar_total - ar0), 16'(aw_total - aw0), 16'(w_total - w0), 16'd0},
              {16'd2, 16'd2, 16'd2, 16'd0});
        check("t4_no_timeout", {63'd0, timeout_err}, 64'd0);

        // instruction fetch, AR accepted after five wait cycles
        ar_delay = 5;
        start_req(32'h100, 32'h0, 4'b0000, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("t2_ar_wait%0d", k), {28'd0, mem_axi_arvalid, mem_axi_arprot, mem_axi_araddr},
                  {28'd0, 1'b1, 3'b100, 32'h100});
        end
        wait_ready(20, 1'b0, lat);
        check("t2_latency", 64'(lat), 64'd8);
        check("t2_rdata", {32'd0, mem_rdata}, 64'h1234_5678);
        ar_delay = 0;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin step(); if (mem_ready) pulses++; end
        check("t2_single_ready", 64'(pulses), 64'd0);

        // watchdog: responder withholds the read data
        do_reset();
        r_en = 1'b0;
        start_req(32'h108, 32'h0, 4'b0000, 1'b0);
        while (cyc < 6) step();
        check("t5_err_early", {62'd0, timeout_err, mem_axi_rready}, 64'd1);
        while (cyc < 12) step();
        check("t5_err_set", {61'd0, timeout_err, mem_axi_rready, mem_axi_arvalid}, 64'd6);
        r_en = 1'b1;
        wait_ready(10, 1'b0, lat);
        check("t5_rdata", {32'd0, mem_rdata}, 64'h5A02_0304);
        step(); step(); step();
        check("t5_err_sticky", {63'd0, timeout_err}, 64'd1);

        // reset asserted while waiting for the write response
        do_reset();
        b_en = 1'b0;
        start_req(32'h208, 32'h7777_7777, 4'b1111, 1'b0);
        step(); step();
        check("t6_in_wb", {61'd0, mem_axi_bready, mem_axi_awvalid, mem_axi_wvalid}, 64'd4);
        resetn = 1'b0;
        mem_valid = 1'b0;
        step();
        check_cleared("t6_abort");
        step();
        resetn = 1'b1;
        b_en = 1'b1;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin step(); if (mem_ready || mem_axi_bready) pulses++; end
        check("t6_no_late_hs", 64'(pulses), 64'd0);
        start_req(32'h100, 32'h0, 4'b0000, 1'b0);
        wait_ready(20, 1'b0, lat);
        check("t6_fresh_latency", 64'(lat), 64'd3);
        check("t6_fresh_rdata", {32'd0, mem_rdata}, 64'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
